icnd2110_in: RTL and testbench

Deserializer for the ICND2110 serial LED stream. It oversamples an external `clock_in`/`data_in` pair in the `clk` domain and locks onto the 128-one start marker. It then decodes the configuration word and each chip's 12 channel words, and writes them to word memory in logical channel order (chip n, channel c → `START_ADDRESS + 12n + c`). It is the receive-side counterpart of the ICND2110 output serializer, used for loopback checking and for chip emulation.

---
 rtl/icnd2110_in.sv | 152 +++++++++++++++
 tb/tb_icnd2110_in.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/icnd2110_in.sv
// icnd2110_in: deserializer for the ICND2110 serial LED stream into word memory
module icnd2110_in #(
  parameter int START_ADDRESS = 0,
  parameter int WORD_COUNT = 336,
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int START_ONES = 128,
  parameter int END_ONES = 145
) (
  input  logic clk,
  input  logic rst,
  input  logic clock_in,
  input  logic data_in,
  output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  output logic [15:0] write_data,
  output logic write_strobe,
  output logic [15:0] cfg_word,
  output logic cfg_strobe,
  output logic frame_done,
  output logic frame_error,
  output logic [7:0] chip_count
);
  localparam logic [2:0] ST_HUNT = 3'd0, ST_BLANK = 3'd1, ST_REG = 3'd2, ST_GRP_A = 3'd3, ST_GRP_B = 3'd4, ST_END = 3'd5;
  localparam logic [7:0] START_RUN = 8'(START_ONES);
  localparam logic [7:0] END_RUN = 8'(END_ONES);
  typedef logic [ADDRESS_BUS_WIDTH-1:0] addr_t;
  logic [1:0] clk_s, dat_s;
  logic clk_d, bit_ok, b, full, go_a, go_b, ovf, busy, side;
  logic [2:0] state, target, k;
  logic [7:0] run, run_inc;
  logic [6:0] cnt;
  logic [95:0] buf_q, sh;
  logic [3:0] ch;
  addr_t base;
  always_comb begin
    bit_ok = clk_s[1] & ~clk_d;
    b = dat_s[1];
    run_inc = run == 8'hff ? run : run + 8'd1;
    full = 32'(chip_count) * 32'd12 + 32'd11 >= 32'(WORD_COUNT);
    go_a = bit_ok & state == ST_GRP_A & cnt == 7'd96 & ~b;
    go_b = bit_ok & state == ST_GRP_B & cnt == 7'd95;
    sh = buf_q << {k, 4'd0};
    ch = side ? 4'd11 - {1'b0, k} : 4'd5 - {1'b0, k};
    write_strobe = busy;
    write_data = busy ? sh[95:80] : '0;
    write_address = busy ? base + addr_t'(ch) : '0;
  end
  // two-flop synchronizers and rising-edge history for the serial clock
  always_ff @(posedge clk) begin
    clk_s <= rst ? 2'b00 : {clk_s[0], clock_in};
    dat_s <= rst ? 2'b00 : {dat_s[0], data_in};
    clk_d <= rst ? 1'b0 : clk_s[1];
  end
  // commit sequencer: six back-to-back writes of the buffered group, first word first
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      side <= 1'b0;
      k <= '0;
      base <= '0;
    end else if (go_a | go_b) begin
      busy <= ~full;
      side <= go_b;
      k <= '0;
      base <= addr_t'(START_ADDRESS) + addr_t'(chip_count) * addr_t'(12);
    end else if (busy) begin
      k <= k + 3'd1;
      busy <= k != 3'd5;
    end
  end
  // frame decoder, advancing once per sampled bit
  always_ff @(posedge clk) begin
    cfg_strobe <= 1'b0;
    frame_done <= 1'b0;
    frame_error <= 1'b0;
    if (rst) begin
      state <= ST_HUNT;
      target <= ST_HUNT;
      run <= '0;
      cnt <= '0;
      buf_q <= '0;
      ovf <= 1'b0;
      cfg_word <= '0;
      chip_count <= '0;
    end else if (bit_ok) begin
      case (state)
        ST_HUNT: begin
          run <= b ? run_inc : '0;
          if (!b && run == START_RUN) begin
            state <= ST_BLANK;
            target <= ST_REG;
            cnt <= 7'd1;
          end
        end
        ST_BLANK:
          if (b) begin
            frame_error <= 1'b1;
            state <= ST_HUNT;
            run <= 8'd1;
          end else if (cnt == 7'd15) begin
            state <= target;
            cnt <= '0;
            if (target == ST_REG) begin
              chip_count <= '0;
              ovf <= 1'b0;
            end
          end else cnt <= cnt + 7'd1;
        ST_REG: begin
          buf_q <= {buf_q[94:0], b};
          cnt <= cnt == 7'd15 ? '0 : cnt + 7'd1;
          if (cnt == 7'd15) begin
            cfg_word <= {buf_q[14:0], b};
            cfg_strobe <= 1'b1;
            state <= ST_BLANK;
            target <= ST_GRP_A;
          end
        end
        ST_GRP_A:
          if (cnt != 7'd96) begin
            buf_q <= {buf_q[94:0], b};
            cnt <= cnt + 7'd1;
          end else if (b) begin
            state <= ST_END;
            run <= 8'd97;
          end else begin
            ovf <= ovf | full;
            state <= ST_BLANK;
            target <= ST_GRP_B;
            cnt <= 7'd1;
          end
        ST_GRP_B: begin
          buf_q <= {buf_q[94:0], b};
          cnt <= cnt == 7'd95 ? '0 : cnt + 7'd1;
          if (cnt == 7'd95) begin
            ovf <= ovf | full;
            chip_count <= chip_count + 8'd1;
            state <= ST_BLANK;
            target <= ST_GRP_A;
          end
        end
        ST_END:
          if (b) run <= run_inc;
          else begin
            frame_done <= run == END_RUN && !ovf;
            frame_error <= !(run == END_RUN && !ovf);
            state <= ST_HUNT;
            run <= '0;
          end
        default: state <= ST_HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_icnd2110_in.sv
// tb_icnd2110_in: scoreboard bench for the ICND2110 stream deserializer
module tb_icnd2110_in;
  logic clk = 1'b0, rst = 1'b1, clock_in = 1'b0, data_in = 1'b0;
  logic [11:0] write_address;
  logic [15:0] write_data, cfg_word;
  logic write_strobe, cfg_strobe, frame_done, frame_error;
  logic [7:0] chip_count;
  logic [27:0] exp_w;
  logic [27:0] sb[$];
  int checks = 0, failures = 0;
  int wr_n = 0, cfg_n = 0, done_n = 0, err_n = 0;

  icnd2110_in dut (
    .clk(clk), .rst(rst), .clock_in(clock_in), .data_in(data_in),
    .write_address(write_address), .write_data(write_data), .write_strobe(write_strobe),
    .cfg_word(cfg_word), .cfg_strobe(cfg_strobe), .frame_done(frame_done),
    .frame_error(frame_error), .chip_count(chip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write_strobe) begin
      wr_n++;
      check("wr_avail", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check("wr_addr", 32'(write_address), 32'(exp_w[27:16]));
        check("wr_data", 32'(write_data), 32'(exp_w[15:0]));
      end
    end
    if (cfg_strobe) cfg_n++;
    if (frame_done) done_n++;
    if (frame_error) err_n++;
  end

  task automatic send_bit(input logic v);
    data_in = v;
    #20 clock_in = 1'b1;
    #20 clock_in = 1'b0;
  endtask

  task automatic send_run(input logic v, input int n);
    repeat (n) send_bit(v);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  function automatic logic [15:0] word_val(input int n, input int c, input logic ones);
    return (ones && n == 0) ? 16'hffff : 16'(16'h1000 + 16 * n + c);
  endfunction

  task automatic send_group(input int n, input logic hi, input logic ones, input logic push);
    int c;
    for (int j = 0; j < 6; j++) begin
      c = hi ? 11 - j : 5 - j;
      if (push && 12 * n + 11 < 336) sb.push_back({12'(12 * n + c), word_val(n, c, ones)});
      send_word(word_val(n, c, ones));
    end
  endtask

  task automatic send_frame(input logic [15:0] cfg, input int chips, input logic ones, input int end_ones);
    send_run(1'b1, 128);
    send_run(1'b0, 16);
    send_word(cfg);
    send_run(1'b0, 16);
    for (int n = 0; n < chips; n++) begin
      send_group(n, 1'b0, ones, 1'b1);
      send_run(1'b0, 16);
      send_group(n, 1'b1, ones, 1'b1);
      send_run(1'b0, 16);
    end
    send_run(1'b1, end_ones);
    send_run(1'b0, 20);
  endtask

  task automatic clear_counts();
    wr_n = 0;
    cfg_n = 0;
    done_n = 0;
    err_n = 0;
  endtask

  task automatic frame_checks(input string t, input int wr, input int done, input int err, input int chips);
    check({t, "_writes"}, wr_n, wr);
    check({t, "_sb_left"}, sb.size(), 0);
    check({t, "_done"}, done_n, done);
    check({t, "_error"}, err_n, err);
    check({t, "_chips"}, 32'(chip_count), chips);
  endtask

  task automatic check_zero(input string t);
    check({t, "_addr"}, 32'(write_address), 0);
    check({t, "_data"}, 32'(write_data), 0);
    check({t, "_strobe"}, 32'(write_strobe), 0);
    check({t, "_cfg"}, 32'(cfg_word), 0);
    check({t, "_cfgstb"}, 32'(cfg_strobe), 0);
    check({t, "_chips"}, 32'(chip_count), 0);
    check({t, "_done"}, 32'(frame_done), 0);
    check({t, "_err"}, 32'(frame_error), 0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    clear_counts();
    send_frame(16'h0007, 1, 1'b0, 145);
    frame_checks("single", 12, 1, 0, 1);
    check("single_cfg", 32'(cfg_word), 32'h0007);
    check("single_cfg_n", cfg_n, 1);
    clear_counts();
    send_frame(16'h0102, 2, 1'b1, 145);
    frame_checks("ones", 24, 1, 0, 2);
    check("ones_cfg", 32'(cfg_word), 32'h0102);
    clear_counts();
    send_run(1'b1, 128);
    send_run(1'b0, 16);
    send_word(16'h00a5);
    send_run(1'b0, 3);
    send_bit(1'b1);
    send_run(1'b0, 20);
    check("blank_err", err_n, 1);
    check("blank_writes", wr_n, 0);
    check("blank_done", done_n, 0);
    check("blank_cfg_n", cfg_n, 1);
    clear_counts();
    send_frame(16'h0033, 1, 1'b0, 145);
    frame_checks("recover", 12, 1, 0, 1);
    check("recover_cfg", 32'(cfg_word), 32'h0033);
    clear_counts();
    send_frame(16'h0011, 29, 1'b0, 145);
    frame_checks("ovf", 336, 0, 1, 29);
    clear_counts();
    send_frame(16'h0044, 1, 1'b0, 150);
    frame_checks("bad_end", 12, 0, 1, 1);
    clear_counts();
    send_run(1'b1, 145);
    send_run(1'b0, 100);
    check("lone_end_cfg_n", cfg_n, 0);
    check("lone_end_writes", wr_n, 0);
    check("lone_end_done", done_n, 0);
    check("lone_end_err", err_n, 0);
    clear_counts();
    send_run(1'b1, 128);
    send_run(1'b0, 16);
    send_word(16'h0055);
    send_run(1'b0, 16);
    send_group(0, 1'b0, 1'b0, 1'b1);
    send_run(1'b0, 16);
    for (int j = 0; j < 3; j++) send_word(word_val(0, 11 - j, 1'b0));
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    check_zero("postrst");
    send_run(1'b0, 20);
    check("midrst_writes", wr_n, 6);
    check("midrst_sb_left", sb.size(), 0);
    check("midrst_done", done_n, 0);
    check("midrst_err", err_n, 0);
    clear_counts();
    send_frame(16'h0066, 1, 1'b0, 145);
    frame_checks("after_rst", 12, 1, 0, 1);
    check("after_rst_cfg", 32'(cfg_word), 32'h0066);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
